// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP stream engine: FSM states, neighbour bit
// mapping, and the column-major read order of the 3x3 window.
package lbp_pkg;

  typedef enum logic [2:0] {IDLE, FILL, SLIDE, EMIT, BORDER, DONE} state_t;

  // Window slot k = col*3 + row, with col/row 0..2 relative to (r-1, c-1)
  localparam int CTR_IDX = 4;
  localparam int NBR_IDX [8] = '{0, 3, 6, 1, 7, 2, 5, 8};

  localparam int RD_ROW_OFF [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam int RD_COL_OFF [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

  localparam logic [3:0] SLIDE_K0   = 4'd6;
  localparam logic [3:0] FILL_LAST  = 4'd9;
  localparam logic [3:0] SLIDE_LAST = 4'd3;

  function automatic int rd_offset(input logic [3:0] k, input int img_w);
    return RD_ROW_OFF[k] * img_w + RD_COL_OFF[k];
  endfunction

endpackage

// File: rtl/lbp_window_cmp.sv
// Combinational 3x3 window to 8-bit LBP code; bit set when neighbour >= centre.
// Zero latency, no flow control.
module lbp_window_cmp
  import lbp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [9*DATA_W-1:0] win,
  output logic [7:0]          code
);

  for (genvar b = 0; b < 8; b++) begin : g_bit
    assign code[b] = win[NBR_IDX[b]*DATA_W +: DATA_W] >= win[CTR_IDX*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/lbp_stream_engine.sv
// Raster-scans a gray image through a 1-cycle read port and writes one LBP code per pixel.
// First code of a row 10 cycles after its first read, then one every 4 cycles; no backpressure.
module lbp_stream_engine
  import lbp_pkg::*;
#(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 14,
  parameter int BORDER_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              lbp_valid,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int CW = $clog2(IMG_W) + 1;
  localparam int RW = $clog2(IMG_H) + 1;
  localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 2);
  localparam logic [CW-1:0]     COL_MAX   = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 2);
  localparam logic [RW-1:0]     ROW_MAX   = RW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] FIRST_CTR = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] COL_JUMP  = ADDR_W'(IMG_W - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q;
  logic [RW-1:0]        row_q;
  logic [CW-1:0]        col_q;
  logic [ADDR_W-1:0]    ctr_q;
  logic [9*DATA_W-1:0]  win_q, cmp_win;
  logic                 rd_vld_q;
  logic [3:0]           rd_idx_q;
  logic                 rd_req;
  logic [3:0]           rd_k;
  logic [ADDR_W-1:0]    rd_base;
  logic                 more_cols, more_rows, last_rd, border_last;
  logic [7:0]           code;
  logic                 lbp_valid_q;
  logic [ADDR_W-1:0]    lbp_addr_q;
  logic [7:0]           lbp_data_q;

  assign more_cols   = col_q < COL_LAST;
  assign more_rows   = row_q < ROW_LAST;
  assign last_rd     = (state_q == FILL && cnt_q == FILL_LAST) ||
                       (state_q == SLIDE && cnt_q == SLIDE_LAST);
  assign border_last = (row_q == ROW_MAX) && (col_q == COL_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // EMIT already issues the first read of the following window so reads never bubble
  always_comb begin
    state_d = state_q;
    rd_req  = 1'b0;
    rd_k    = '0;
    rd_base = ctr_q;
    case (state_q)
      IDLE: if (gray_ready) state_d = FILL;
      FILL: begin
        if (cnt_q < FILL_LAST) begin
          rd_req = 1'b1;
          rd_k   = cnt_q;
        end else begin
          state_d = EMIT;
        end
      end
      SLIDE: begin
        if (cnt_q < SLIDE_LAST) begin
          rd_req = 1'b1;
          rd_k   = cnt_q + SLIDE_K0;
        end else begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (more_cols) begin
          state_d = SLIDE;
          rd_req  = 1'b1;
          rd_k    = SLIDE_K0;
          rd_base = ctr_q + ADDR_W'(1);
        end else if (more_rows) begin
          state_d = FILL;
          rd_req  = 1'b1;
          rd_base = ctr_q + ADDR_W'(3);
        end else begin
          state_d = (BORDER_ZERO != 0) ? BORDER : DONE;
        end
      end
      BORDER: if (border_last) state_d = DONE;
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign gray_req  = rd_req;
  assign gray_addr = rd_req ? rd_base + ADDR_W'(rd_offset(rd_k, IMG_W)) : '0;
  assign finish    = (state_q == DONE);
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;

  // The last read of a window lands in the same cycle the code is registered
  always_comb begin
    cmp_win = win_q;
    if (rd_vld_q) cmp_win[rd_idx_q*DATA_W +: DATA_W] = gray_data;
  end

  lbp_window_cmp #(.DATA_W(DATA_W)) u_cmp (
    .win  (cmp_win),
    .code (code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ctr_q       <= '0;
      win_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
    end else begin
      rd_vld_q    <= rd_req;
      rd_idx_q    <= rd_k;
      lbp_valid_q <= 1'b0;
      if (rd_vld_q) win_q[rd_idx_q*DATA_W +: DATA_W] <= gray_data;
      case (state_q)
        IDLE: begin
          if (gray_ready) begin
            row_q <= RW'(1);
            col_q <= CW'(1);
            ctr_q <= FIRST_CTR;
            cnt_q <= '0;
          end
        end
        FILL, SLIDE: begin
          cnt_q <= cnt_q + 4'd1;
          if (last_rd) begin
            lbp_valid_q <= 1'b1;
            lbp_addr_q  <= ctr_q;
            lbp_data_q  <= code;
          end
        end
        EMIT: begin
          if (more_cols) begin
            col_q <= col_q + CW'(1);
            ctr_q <= ctr_q + ADDR_W'(1);
            cnt_q <= 4'd1;
            win_q[6*DATA_W-1:0] <= win_q[9*DATA_W-1:3*DATA_W];
          end else if (more_rows) begin
            row_q <= row_q + RW'(1);
            col_q <= CW'(1);
            ctr_q <= ctr_q + ADDR_W'(3);
            cnt_q <= 4'd1;
          end else if (BORDER_ZERO != 0) begin
            row_q       <= '0;
            col_q       <= '0;
            lbp_valid_q <= 1'b1;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
          end
        end
        BORDER: begin
          // row/col track the border pixel currently on the write port
          if (!border_last) begin
            lbp_valid_q <= 1'b1;
            lbp_data_q  <= '0;
            if (row_q == '0 || row_q == ROW_MAX) begin
              if (col_q < COL_MAX) begin
                col_q <= col_q + CW'(1);
              end else begin
                row_q <= row_q + RW'(1);
                col_q <= '0;
              end
              lbp_addr_q <= lbp_addr_q + ADDR_W'(1);
            end else if (col_q == '0) begin
              col_q      <= COL_MAX;
              lbp_addr_q <= lbp_addr_q + COL_JUMP;
            end else begin
              row_q      <= row_q + RW'(1);
              col_q      <= '0;
              lbp_addr_q <= lbp_addr_q + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Scoreboard bench: four engine configurations, expected writes queued at stimulus time
// and popped by a single negedge monitor.
module tb_lbp_stream_engine;

  localparam int NI = 4;
  localparam int AW = 14;
  localparam int IW [NI] = '{8, 8, 16, 128};
  localparam int IH [NI] = '{8, 8, 16, 128};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_n, rdy, req, vld, fin;
  logic [AW-1:0] gaddr [NI];
  logic [AW-1:0] laddr [NI];
  logic [7:0]    gdat  [NI];
  logic [7:0]    ldat  [NI];
  logic [7:0]    mem   [NI][16384];
  logic [AW+7:0] exp_q [NI][$];

  int checks = 0;
  int errors = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;
  int cyc = 0;
  int req_cyc [NI];
  int nwr [NI];
  logic [NI-1:0] prev_vld = '0;
  logic [NI-1:0] prev_fin = '0;
  logic [AW+7:0] mon_e;

  lbp_stream_engine #(.IMG_W(8), .IMG_H(8), .DATA_W(8), .ADDR_W(14), .BORDER_ZERO(1)) u_a (
    .clk(clk), .reset(rst_n[0]), .gray_ready(rdy[0]), .gray_req(req[0]), .gray_addr(gaddr[0]),
    .gray_data(gdat[0]), .lbp_addr(laddr[0]), .lbp_valid(vld[0]), .lbp_data(ldat[0]), .finish(fin[0]));
  lbp_stream_engine #(.IMG_W(8), .IMG_H(8), .DATA_W(8), .ADDR_W(14), .BORDER_ZERO(0)) u_b (
    .clk(clk), .reset(rst_n[1]), .gray_ready(rdy[1]), .gray_req(req[1]), .gray_addr(gaddr[1]),
    .gray_data(gdat[1]), .lbp_addr(laddr[1]), .lbp_valid(vld[1]), .lbp_data(ldat[1]), .finish(fin[1]));
  lbp_stream_engine #(.IMG_W(16), .IMG_H(16), .DATA_W(8), .ADDR_W(14), .BORDER_ZERO(0)) u_c (
    .clk(clk), .reset(rst_n[2]), .gray_ready(rdy[2]), .gray_req(req[2]), .gray_addr(gaddr[2]),
    .gray_data(gdat[2]), .lbp_addr(laddr[2]), .lbp_valid(vld[2]), .lbp_data(ldat[2]), .finish(fin[2]));
  lbp_stream_engine u_d (
    .clk(clk), .reset(rst_n[3]), .gray_ready(rdy[3]), .gray_req(req[3]), .gray_addr(gaddr[3]),
    .gray_data(gdat[3]), .lbp_addr(laddr[3]), .lbp_valid(vld[3]), .lbp_data(ldat[3]), .finish(fin[3]));

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++)
      if (req[i]) gdat[i] <= mem[i][gaddr[i]];
  end

  function automatic logic [7:0] lbp_ref(input int i, input int r, input int c);
    int w;
    logic [7:0] ctr;
    logic [7:0] code;
    w = IW[i];
    ctr = mem[i][r*w + c];
    code[0] = mem[i][(r-1)*w + c-1] >= ctr;
    code[1] = mem[i][(r-1)*w + c]   >= ctr;
    code[2] = mem[i][(r-1)*w + c+1] >= ctr;
    code[3] = mem[i][r*w + c-1]     >= ctr;
    code[4] = mem[i][r*w + c+1]     >= ctr;
    code[5] = mem[i][(r+1)*w + c-1] >= ctr;
    code[6] = mem[i][(r+1)*w + c]   >= ctr;
    code[7] = mem[i][(r+1)*w + c+1] >= ctr;
    return code;
  endfunction

  // Monitor: the only process that compares and counts
  always @(negedge clk) begin
    cyc++;
    if (tmo_cnt != tmo_seen) begin
      tmo_seen = tmo_cnt;
      checks++; errors++;
      $display("FAIL timeout: wait expired, got no finish, required finish=1");
    end
    for (int i = 0; i < NI; i++) begin
      if (rst_n[i] === 1'b0) begin
        checks++;
        if ({req[i], gaddr[i], vld[i], laddr[i], ldat[i], fin[i]} !== '0) begin
          errors++;
          $display("FAIL reset_outputs[%0d]: req=%b gaddr=%0d vld=%b laddr=%0d ldat=%h fin=%b, required all 0",
                   i, req[i], gaddr[i], vld[i], laddr[i], ldat[i], fin[i]);
        end
        req_cyc[i] = -1;
        nwr[i] = 0;
      end else begin
        if (req[i]) begin
          if (req_cyc[i] < 0) req_cyc[i] = cyc;
          checks++;
          if (int'(gaddr[i]) >= IW[i] * IH[i]) begin
            errors++;
            $display("FAIL addr_bound[%0d]: gray_addr=%0d, required < %0d", i, gaddr[i], IW[i] * IH[i]);
          end
        end
        if (vld[i]) begin
          nwr[i]++;
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL extra_write[%0d]: addr=%0d data=%h, required no write", i, laddr[i], ldat[i]);
          end else begin
            mon_e = exp_q[i].pop_front();
            if ({laddr[i], ldat[i]} !== mon_e || fin[i] !== 1'b0) begin
              errors++;
              $display("FAIL write[%0d]: addr=%0d data=%h fin=%b, required addr=%0d data=%h fin=0",
                       i, laddr[i], ldat[i], fin[i], mon_e[AW+7:8], mon_e[7:0]);
            end
          end
          if (nwr[i] == 1 || nwr[i] == 2) begin
            checks++;
            if (cyc - req_cyc[i] != ((nwr[i] == 1) ? 10 : 14)) begin
              errors++;
              $display("FAIL latency[%0d] write %0d: got %0d cycles after first req, required %0d",
                       i, nwr[i], cyc - req_cyc[i], (nwr[i] == 1) ? 10 : 14);
            end
          end
        end
        if (fin[i] === 1'b1 && prev_fin[i] !== 1'b1) begin
          checks++;
          if (prev_vld[i] !== 1'b1 || exp_q[i].size() != 0) begin
            errors++;
            $display("FAIL finish[%0d]: prev_valid=%b pending=%0d, required prev_valid=1 pending=0",
                     i, prev_vld[i], exp_q[i].size());
          end
        end
      end
      prev_vld[i] = vld[i];
      prev_fin[i] = fin[i];
    end
  end

  task automatic push_exp(input int i, input int a, input logic [7:0] d);
    exp_q[i].push_back({AW'(a), d});
  endtask

  task automatic push_border(input int i);
    for (int r = 0; r < IH[i]; r++)
      for (int c = 0; c < IW[i]; c++)
        if (r == 0 || r == IH[i]-1 || c == 0 || c == IW[i]-1) push_exp(i, r*IW[i] + c, 8'h00);
  endtask

  task automatic push_const(input int i, input logic [7:0] d);
    for (int r = 1; r < IH[i]-1; r++)
      for (int c = 1; c < IW[i]-1; c++) push_exp(i, r*IW[i] + c, d);
  endtask

  task automatic start(input int i);
    @(posedge clk); #1 rdy[i] = 1'b1;
    @(posedge clk); #1 rdy[i] = 1'b0;
  endtask

  task automatic do_reset(input int i);
    @(posedge clk); #1 rst_n[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n[i] = 1'b1;
  endtask

  task automatic wait_fin(input int i, input int budget);
    int n;
    n = 0;
    while (fin[i] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (fin[i] !== 1'b1) tmo_cnt++;
  endtask

  initial begin
    int n;
    rst_n = '0;
    rdy   = '0;
    for (int a = 0; a < 16384; a++) mem[3][a] = 8'($urandom);
    for (int a = 0; a < 64; a++) begin
      mem[0][a] = 8'h55;
      mem[1][a] = 8'(a);
    end
    for (int a = 0; a < 256; a++) mem[2][a] = 8'(a);
    repeat (3) @(posedge clk);
    #1 rst_n = '1;

    // 128x128 random image against the direct neighbourhood model, runs alongside the rest
    for (int r = 1; r < 127; r++)
      for (int c = 1; c < 127; c++) push_exp(3, r*128 + c, lbp_ref(3, r, c));
    push_border(3);
    start(3);

    // Constant 0x55: every interior neighbour equals the centre
    push_const(0, 8'hFF);
    push_border(0);
    start(0);
    wait_fin(0, 1000);

    // Single bright pixel at (3,3): only its own code drops to 0x00
    do_reset(0);
    for (int a = 0; a < 64; a++) mem[0][a] = 8'h10;
    mem[0][27] = 8'hFF;
    for (int r = 1; r < 7; r++)
      for (int c = 1; c < 7; c++) push_exp(0, r*8 + c, (r*8 + c == 27) ? 8'h00 : 8'hFF);
    push_border(0);
    start(0);
    wait_fin(0, 1000);

    // Ramp: upper/left neighbours smaller, right/lower larger -> 0xF0
    push_const(1, 8'hF0);
    start(1);
    wait_fin(1, 1000);

    // 16x16 ramp, reset during the third scan row, then a full rerun
    push_const(2, 8'hF0);
    start(2);
    n = 0;
    while (!(vld[2] === 1'b1 && laddr[2] >= AW'(48)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) tmo_cnt++;
    @(posedge clk); #2 rst_n[2] = 1'b0;
    exp_q[2].delete();
    repeat (2) @(posedge clk);
    #1 rst_n[2] = 1'b1;
    push_const(2, 8'hF0);
    start(2);
    wait_fin(2, 3000);

    wait_fin(3, 80000);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
